// File: rtl/pulse_spacer_pkg.sv
// Shared types for the pulse spacer: FSM state encodings and the gap counter sizing helper.
package pulse_spacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Gap counter width: clog2(gap), never narrower than one bit.
  function automatic int gap_cnt_width(input int gap);
    int w;
    w = $clog2(gap);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_spacer.sv
// Queues single-cycle event pulses and re-issues them at least GAP src_clk cycles apart,
// ahead of a toggle-based pulse synchroniser; events arriving on a full queue are dropped and flagged.
module pulse_spacer
  import pulse_spacer_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int GAP   = 4
) (
  input  logic             src_clk,
  input  logic             src_rst,
  input  logic             pulse_in,
  input  logic             ovf_clr,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam int               GW       = gap_cnt_width(GAP);
  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP - 2);
  localparam logic [GW-1:0]    GAP_ONE  = GW'(1);

  if (GAP < 2) begin : g_gap_check
    $error("pulse_spacer: GAP must be at least 2");
  end

  state_t           state_r;
  state_t           state_nx_s;
  logic [GW-1:0]    gap_cnt_r;
  logic             work_s;
  logic             issue_s;
  logic             accept_s;
  logic             drop_s;
  logic [CNT_W-1:0] pending_nx_s;

  // Issue/accept decisions and the next queue depth and state.
  always_comb begin
    work_s   = (pending != {CNT_W{1'b0}}) | pulse_in;
    issue_s  = work_s & ((state_r == ST_IDLE) |
                         ((state_r == ST_WAIT) & (gap_cnt_r == {GW{1'b0}})));
    accept_s = pulse_in & ((pending != PEND_MAX) | issue_s);
    drop_s   = pulse_in & ~accept_s;

    if (accept_s && !issue_s) begin
      pending_nx_s = pending + PEND_ONE;
    end else if (!accept_s && issue_s) begin
      pending_nx_s = pending - PEND_ONE;
    end else begin
      pending_nx_s = pending;
    end

    case (state_r)
      ST_IDLE: state_nx_s = issue_s ? ST_FIRE : ST_IDLE;
      ST_FIRE: state_nx_s = ST_WAIT;
      ST_WAIT: begin
        if (gap_cnt_r != {GW{1'b0}}) begin
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = issue_s ? ST_FIRE : ST_IDLE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM, gap timer, queue depth and registered status outputs.
  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      state_r   <= ST_IDLE;
      gap_cnt_r <= {GW{1'b0}};
      pending   <= {CNT_W{1'b0}};
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (state_r == ST_FIRE) begin
        gap_cnt_r <= GAP_LOAD;
      end else if ((state_r == ST_WAIT) && (gap_cnt_r != {GW{1'b0}})) begin
        gap_cnt_r <= gap_cnt_r - GAP_ONE;
      end else begin
        gap_cnt_r <= gap_cnt_r;
      end
      pending   <= pending_nx_s;
      pulse_out <= (state_nx_s == ST_FIRE);
      busy      <= (state_nx_s != ST_IDLE) | (pending_nx_s != {CNT_W{1'b0}});
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_pulse_spacer.sv
// Directed bench for pulse_spacer (CNT_W=2, GAP=4) plus an end-to-end run through a toggle synchroniser model.
module tb_pulse_spacer;

  localparam int CNT_W = 2;
  localparam int GAP   = 4;

  logic             src_clk  = 1'b0;
  logic             src_rst  = 1'b1;
  logic             pulse_in = 1'b0;
  logic             ovf_clr  = 1'b0;
  logic             pulse_out;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  int npulse;
  int exp_pend2 [0:10] = '{0, 0, 1, 2, 2, 1, 1, 1, 1, 0, 0};

  // Toggle synchroniser model on a slower, offset destination clock.
  logic dst_clk = 1'b0;
  logic tgl = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic cnt_clr = 1'b0;
  int   dst_cnt = 0;

  pulse_spacer #(.CNT_W(CNT_W), .GAP(GAP)) dut (
    .src_clk  (src_clk),
    .src_rst  (src_rst),
    .pulse_in (pulse_in),
    .ovf_clr  (ovf_clr),
    .pulse_out(pulse_out),
    .pending  (pending),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 src_clk = ~src_clk;

  initial begin
    #2;
    forever #15 dst_clk = ~dst_clk;
  end

  always @(posedge src_clk) begin
    if (src_rst) tgl <= 1'b0;
    else if (pulse_out) tgl <= ~tgl;
  end

  always @(posedge dst_clk) begin
    s1 <= tgl;
    s2 <= s1;
    s3 <= s2;
    if (cnt_clr) dst_cnt <= 0;
    else if (s2 ^ s3) dst_cnt <= dst_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Leaves the caller at the start of cycle 0 with src_rst released.
  task automatic do_reset();
    @(negedge src_clk);
    src_rst  = 1'b1;
    pulse_in = 1'b0;
    ovf_clr  = 1'b0;
    @(negedge src_clk);
    @(negedge src_clk);
    chk("rst_pulse_out", 32'(pulse_out), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    src_rst = 1'b0;
  endtask

  initial begin
    // Test 1: single event
    do_reset();
    pulse_in = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge src_clk);
      pulse_in = 1'b0;
      chk("t1_pulse_out", 32'(pulse_out), 32'(c == 1));
      chk("t1_pending", 32'(pending), 32'd0);
      chk("t1_busy", 32'(busy), 32'((c >= 1) && (c <= 4)));
    end

    // Test 2: burst of three
    do_reset();
    pulse_in = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge src_clk);
      pulse_in = (c <= 2);
      chk("t2_pulse_out", 32'(pulse_out), 32'((c == 1) || (c == 5) || (c == 9)));
      if (c <= 10) chk("t2_pending", 32'(pending), 32'(exp_pend2[c]));
      chk("t2_overflow", 32'(overflow), 32'd0);
    end

    // Test 3: overflow on a full queue
    do_reset();
    pulse_in = 1'b1;
    npulse = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge src_clk);
      pulse_in = (c <= 5);
      if (pulse_out === 1'b1) npulse++;
      chk("t3_pulse_out", 32'(pulse_out),
          32'((c == 1) || (c == 5) || (c == 9) || (c == 13) || (c == 17)));
      chk("t3_overflow", 32'(overflow), 32'(c >= 6));
    end
    chk("t3_pulse_count", 32'(npulse), 32'd5);

    // Test 4: clear racing a drop, then clear alone
    do_reset();
    pulse_in = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge src_clk);
      pulse_in = (c <= 5);
      ovf_clr  = (c == 5) || (c == 6);
      if (c == 6) chk("t4_set_wins", 32'(overflow), 32'd1);
      if (c == 7) chk("t4_cleared", 32'(overflow), 32'd0);
    end
    ovf_clr = 1'b0;

    // Test 5: reset in the middle of a burst
    do_reset();
    pulse_in = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge src_clk);
      pulse_in = (c <= 2);
      src_rst  = (c == 6);
      chk("t5_pulse_out", 32'(pulse_out), 32'((c == 1) || (c == 5)));
      if (c == 7) begin
        chk("t5_pending", 32'(pending), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
      end
    end

    // Test 6: end to end through the synchroniser model
    do_reset();
    cnt_clr = 1'b1;
    repeat (12) @(negedge src_clk);
    cnt_clr = 1'b0;
    repeat (6) @(negedge src_clk);
    for (int i = 0; i < 1000; i++) begin
      pulse_in = 1'b1;
      @(negedge src_clk);
      pulse_in = 1'b0;
      repeat ($urandom_range(4, 9)) @(negedge src_clk);
    end
    repeat (40) @(negedge src_clk);
    chk("t6_dst_count", 32'(dst_cnt), 32'd1000);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_pending", 32'(pending), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
